// File: rtl/div_tc_32_16.sv
// 32/16 two's-complement sequential restoring divider with a fixed 34-cycle latency.
// Defining DIV_TC_ZERO_CHK_EN adds a 2-cycle divide-by-zero path that raises dz.
module div_tc_32_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [31:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] acc;
    logic [15:0] dvs_mag;
    logic [15:0] rem;
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;

    logic [31:0] dvd_abs;
    logic [15:0] dvs_abs;
    logic        zero_start;
    logic [16:0] part;
    logic [16:0] diff;
    logic        fits;
    logic [31:0] fix_q;
    logic [15:0] fix_r;
    logic        fix_ovf;

    // 0x8000_0000 and 0x8000 negate to themselves, which read as 2^31 and 2^15 unsigned
    assign dvd_abs = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign dvs_abs = divisor[15]  ? (~divisor + 16'd1)  : divisor;

`ifdef DIV_TC_ZERO_CHK_EN
    logic zero_pend;
    assign zero_start = (divisor == 16'd0);
`else
    assign zero_start = 1'b0;
    assign dz         = 1'b0;
`endif

    // Bring down the next dividend bit into the 17-bit partial remainder; diff[16] is the borrow
    assign part = {rem, acc[31]};
    assign diff = part - {1'b0, dvs_mag};
    assign fits = ~diff[16];

    assign fix_q   = q_neg ? (~acc + 32'd1) : acc;
    assign fix_r   = r_neg ? (~rem + 16'd1) : rem;
    // Only -2^31 / -1 yields a positive 2^31 quotient, which has no 32-bit encoding
    assign fix_ovf = ~q_neg & (acc == 32'h8000_0000) & (dvs_mag != 16'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = zero_start ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 5'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
`ifdef DIV_TC_ZERO_CHK_EN
                if (!zero_pend) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
`else
                done      = 1'b1;
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            dvs_mag   <= '0;
            rem       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
`ifdef DIV_TC_ZERO_CHK_EN
            zero_pend <= 1'b0;
            dz        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        rem     <= '0;
                        dvs_mag <= dvs_abs;
                        q_neg   <= dividend[31] ^ divisor[15];
                        r_neg   <= dividend[31];
`ifdef DIV_TC_ZERO_CHK_EN
                        zero_pend <= zero_start;
                        acc       <= zero_start ? dividend : dvd_abs;
`else
                        acc       <= dvd_abs;
`endif
                    end
                end
                CALC: begin
                    acc <= {acc[30:0], fits};
                    rem <= fits ? diff[15:0] : part[15:0];
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    quotient  <= fix_q;
                    remainder <= fix_r;
                    ovf       <= fix_ovf;
`ifdef DIV_TC_ZERO_CHK_EN
                    dz        <= 1'b0;
`endif
                end
                DONE: begin
`ifdef DIV_TC_ZERO_CHK_EN
                    // Zero-divisor path: acc still holds the raw dividend
                    if (zero_pend) begin
                        zero_pend <= 1'b0;
                        quotient  <= 32'hFFFF_FFFF;
                        remainder <= acc[15:0];
                        ovf       <= 1'b0;
                        dz        <= 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_tc_32_16.sv
// Self-checking bench for div_tc_32_16: directed corner cases plus randomized operands
// compared against a signed-arithmetic reference model.
module tb_div_tc_32_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        dz;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_TC_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    div_tc_32_16 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .dz       (dz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder takes the dividend sign
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic o, output logic z, output logic known);
        longint sa, sb, sq, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = '0; r = '0; o = 1'b0; z = 1'b0; known = 1'b1;
        if (sb == 0) begin
            if (ZCHK) begin
                q = 32'hFFFF_FFFF;
                r = a[15:0];
                z = 1'b1;
            end else begin
                known = 1'b0;
            end
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[15:0];
            o  = (sq == 64'sd2147483648);
        end
    endfunction

    // Called just after a falling edge; start is sampled on the next rising edge (cycle 0)
    task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          output logic [31:0] got_q, output logic [15:0] got_r,
                          output logic got_o, output logic got_z);
        logic [31:0] eq;
        logic [15:0] er;
        logic        eo, ez, qk;
        int          lat, done_cyc, done_cnt, busy_bad;
        model(a, b, eq, er, eo, ez, qk);
        lat = (ZCHK && b == 16'd0) ? 2 : 34;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        done_cyc = 0; done_cnt = 0; busy_bad = 0;
        got_q = '0; got_r = '0; got_o = 1'b0; got_z = 1'b0;
        for (int c = 1; c <= lat + 2; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (busy !== (c <= lat)) busy_bad++;
            if (c == lat) begin
                got_q = quotient; got_r = remainder; got_o = ovf; got_z = dz;
            end
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(lat));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_profile"}, 64'(busy_bad), 64'd0);
        check({tag, "_ovf"}, 64'(got_o), 64'(eo));
        check({tag, "_dz"}, 64'(got_z), 64'(ez));
        if (qk) begin
            check({tag, "_quotient"}, 64'(got_q), 64'(eq));
            check({tag, "_remainder"}, 64'(got_r), 64'(er));
            check({tag, "_quotient_hold"}, 64'(quotient), 64'(eq));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, a, prod;
        logic [15:0] r, b;
        logic        o, z;
        int          dc, first_done, second_done, busy_after, busy35;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        check("reset_outputs", 64'({quotient, remainder, busy, done, ovf, dz}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("p100_p7", 32'd100, 16'd7, q, r, o, z);
        check("p100_p7_q_const", 64'(q), 64'h0000_000E);
        check("p100_p7_r_const", 64'(r), 64'h0002);
        run_op("m100_p7", 32'hFFFF_FF9C, 16'h0007, q, r, o, z);
        check("m100_p7_q_const", 64'(q), 64'hFFFF_FFF2);
        check("m100_p7_r_const", 64'(r), 64'hFFFE);
        run_op("p100_m7", 32'd100, 16'hFFF9, q, r, o, z);
        check("p100_m7_q_const", 64'(q), 64'hFFFF_FFF2);
        check("p100_m7_r_const", 64'(r), 64'h0002);
        run_op("min_m1", 32'h8000_0000, 16'hFFFF, q, r, o, z);
        check("min_m1_q_const", 64'(q), 64'h8000_0000);
        check("min_m1_ovf_const", 64'(o), 64'd1);
        run_op("min_min16", 32'h8000_0000, 16'h8000, q, r, o, z);
        check("min_min16_q_const", 64'(q), 64'h0001_0000);
        check("min_min16_ovf_const", 64'(o), 64'd0);
        run_op("min_p1", 32'h8000_0000, 16'h0001, q, r, o, z);

        prod = 32'h3A86 * 32'h794D;
        run_op("mul_round_trip", prod, 16'h794D, q, r, o, z);
        check("mul_round_trip_q_const", 64'(q), 64'h0000_3A86);
        check("mul_round_trip_r_const", 64'(r), 64'h0000);

        run_op("div_zero", 32'h1234_5678, 16'h0000, q, r, o, z);
        if (ZCHK) begin
            check("div_zero_q_const", 64'(q), 64'hFFFF_FFFF);
            check("div_zero_r_const", 64'(r), 64'h5678);
        end
        check("div_zero_dz_const", 64'(z), 64'(ZCHK));

        // A second start in cycle 10 must be dropped, not queued
        dividend = 32'd100; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        dc = 0; first_done = 0; busy_after = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 10);
            if (c == 10) begin dividend = 32'h7FFF_0000; divisor = 16'd3; end
            if (done === 1'b1) begin dc++; if (first_done == 0) first_done = c; end
            if (c > 34 && busy !== 1'b0) busy_after++;
            if (c == 34) q = quotient;
        end
        check("restart_done_count", 64'(dc), 64'd1);
        check("restart_done_cycle", 64'(first_done), 64'd34);
        check("restart_quotient", 64'(q), 64'h0000_000E);
        check("restart_no_queue", 64'(busy_after), 64'd0);

        // Reset in cycle 15 aborts silently; next start is accepted on the following edge
        dividend = 32'h7FFF_FFFF; divisor = 16'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop_reset_outputs", 64'({quotient, remainder, busy, done, ovf, dz}), 64'd0);
        dc = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
        end
        check("midop_reset_no_done", 64'(dc), 64'd0);
        rst = 1'b0;
        run_op("after_reset", 32'hFFF0_0001, 16'h0123, q, r, o, z);

        // start held high: the second operation begins on the IDLE cycle after DONE
        dividend = 32'd100; divisor = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        dc = 0; first_done = 0; second_done = 0; busy35 = 1;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc++;
                if (first_done == 0) first_done = c; else second_done = c;
            end
            if (c == 35) busy35 = busy;
            if (c == 69) begin q = quotient; start = 1'b0; end
        end
        check("held_done_count", 64'(dc), 64'd2);
        check("held_first_done", 64'(first_done), 64'd34);
        check("held_second_done", 64'(second_done), 64'd69);
        check("held_idle_gap", 64'(busy35), 64'd0);
        check("held_quotient", 64'(q), 64'h0000_000E);

        for (int i = 0; i < 24; i++) begin
            a = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
            b = (i % 3 == 0) ? 16'($urandom_range(1, 9)) : 16'($urandom);
            if (i % 4 == 1) b = -b;
            run_op($sformatf("rand%0d", i), a, b, q, r, o, z);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
